// File: rtl/vram_port_arbiter_if.sv
// Front-end side bundle of the VRAM arbiter: display read port, host port and fill control.
// The master modport is the GPU front end; the slave modport is the arbiter.
interface vram_port_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  logic              disp_req_valid;
  logic              disp_req_ready;
  logic [ADDR_W-1:0] disp_req_addr;
  logic              disp_rsp_valid;
  logic [DATA_W-1:0] disp_rsp_data;
  logic              host_req_valid;
  logic              host_req_ready;
  logic              host_req_we;
  logic [ADDR_W-1:0] host_req_addr;
  logic [DATA_W-1:0] host_req_wdata;
  logic              host_rsp_valid;
  logic [DATA_W-1:0] host_rsp_data;
  logic              fill_start;
  logic [DATA_W-1:0] fill_value;
  logic              fill_busy;
  logic              fill_done;

  modport master (
    output disp_req_valid, disp_req_addr,
    input  disp_req_ready, disp_rsp_valid, disp_rsp_data,
    output host_req_valid, host_req_we, host_req_addr, host_req_wdata,
    input  host_req_ready, host_rsp_valid, host_rsp_data,
    output fill_start, fill_value,
    input  fill_busy, fill_done
  );

  modport slave (
    input  disp_req_valid, disp_req_addr,
    output disp_req_ready, disp_rsp_valid, disp_rsp_data,
    input  host_req_valid, host_req_we, host_req_addr, host_req_wdata,
    output host_req_ready, host_rsp_valid, host_rsp_data,
    input  fill_start, fill_value,
    output fill_busy, fill_done
  );
endinterface

// File: rtl/vram_port_arbiter.sv
// Shares one 1W/1R synchronous VRAM between display scanout, host and a full-memory fill engine.
// Display wins reads unless a host read has already lost MAX_WAIT consecutive cycles.
module vram_port_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  vram_port_arbiter_if.slave bus,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  typedef enum logic [0:0] {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t            state_r, state_nxt_s;
  logic [ADDR_W-1:0] fill_addr_r, fill_addr_nxt_s;
  logic [DATA_W-1:0] fill_val_r, fill_val_nxt_s;
  logic [WAIT_W-1:0] wait_cnt_r, wait_cnt_nxt_s;
  logic              disp_pend_r, host_pend_r, fill_done_r, fill_done_nxt_s;
  logic              host_rd_s, host_gnt_s, disp_gnt_s, host_wr_s;

  // Read arbitration and host write acceptance
  always_comb begin
    host_rd_s = bus.host_req_valid & ~bus.host_req_we;
    if (host_rd_s && (!bus.disp_req_valid || wait_cnt_r == WAIT_MAX)) begin
      host_gnt_s = 1'b1;
    end else begin
      host_gnt_s = 1'b0;
    end
    disp_gnt_s = bus.disp_req_valid & ~host_gnt_s;
    host_wr_s  = bus.host_req_valid & bus.host_req_we & (state_r == IDLE);
  end

  // Fill FSM next state plus starvation counter update
  always_comb begin
    state_nxt_s     = state_r;
    fill_addr_nxt_s = fill_addr_r;
    fill_val_nxt_s  = fill_val_r;
    fill_done_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.fill_start) begin
          state_nxt_s     = FILL;
          fill_addr_nxt_s = {ADDR_W{1'b0}};
          fill_val_nxt_s  = bus.fill_value;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FILL: begin
        fill_addr_nxt_s = fill_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (fill_addr_r == LAST_ADDR) begin
          state_nxt_s     = IDLE;
          fill_done_nxt_s = 1'b1;
        end else begin
          state_nxt_s = FILL;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    if (host_rd_s && !host_gnt_s) begin
      wait_cnt_nxt_s = (wait_cnt_r == WAIT_MAX) ? wait_cnt_r : wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
    end else begin
      wait_cnt_nxt_s = {WAIT_W{1'b0}};
    end
  end

  // State, fill pointer, starvation counter and response-owner registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= IDLE;
      fill_addr_r <= {ADDR_W{1'b0}};
      fill_val_r  <= {DATA_W{1'b0}};
      wait_cnt_r  <= {WAIT_W{1'b0}};
      disp_pend_r <= 1'b0;
      host_pend_r <= 1'b0;
      fill_done_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      fill_addr_r <= fill_addr_nxt_s;
      fill_val_r  <= fill_val_nxt_s;
      wait_cnt_r  <= wait_cnt_nxt_s;
      disp_pend_r <= disp_gnt_s;
      host_pend_r <= host_gnt_s;
      fill_done_r <= fill_done_nxt_s;
    end
  end

  // Port outputs; handshakes and memory strobes are held low while reset is asserted
  always_comb begin
    bus.disp_req_ready = i_rst_n & ~host_gnt_s;
    if (bus.host_req_we) begin
      bus.host_req_ready = i_rst_n & (state_r == IDLE);
    end else begin
      bus.host_req_ready = i_rst_n & host_gnt_s;
    end
    mem_ren   = i_rst_n & (host_gnt_s | disp_gnt_s);
    mem_raddr = host_gnt_s ? bus.host_req_addr : bus.disp_req_addr;
    if (state_r == FILL) begin
      mem_wen   = i_rst_n;
      mem_waddr = fill_addr_r;
      mem_wdata = fill_val_r;
    end else begin
      mem_wen   = i_rst_n & host_wr_s;
      mem_waddr = bus.host_req_addr;
      mem_wdata = bus.host_req_wdata;
    end
    bus.disp_rsp_valid = disp_pend_r;
    bus.disp_rsp_data  = disp_pend_r ? mem_rdata : {DATA_W{1'b0}};
    bus.host_rsp_valid = host_pend_r;
    bus.host_rsp_data  = host_pend_r ? mem_rdata : {DATA_W{1'b0}};
    bus.fill_busy      = (state_r == FILL);
    bus.fill_done      = fill_done_r;
  end
endmodule
